// File: rtl/alu_rs_dispatch_pkg.sv
// Shared types and CDB wakeup / branch-resolve helpers for the ALU dispatch path.
// The optional same-cycle bypass is enabled with ALU_RS_DISPATCH_BYPASS_EN.
package alu_rs_dispatch_pkg;

  localparam int CONTROL_Q_PTR_WIDTH = 2;
  localparam int CONTROL_Q_DEPTH     = 1 << CONTROL_Q_PTR_WIDTH;
  localparam int PHYSICAL_REG_WIDTH  = 6;
  localparam int ROB_PTR_WIDTH       = 4;
  localparam int NUM_CDB             = 4;

  typedef struct packed {
    logic [3:0]                    alu_op;
    logic [31:0]                   imm;
    logic                          use_imm;
    logic [ROB_PTR_WIDTH-1:0]      rob_idx;
    logic [PHYSICAL_REG_WIDTH-1:0] phys_d;
    logic [PHYSICAL_REG_WIDTH-1:0] phys_r1;
    logic                          phys_r1_valid;
    logic [PHYSICAL_REG_WIDTH-1:0] phys_r2;
    logic                          phys_r2_valid;
    logic [CONTROL_Q_DEPTH-1:0]    control_bit_map;
    logic                          finished;
  } alu_rs_entry_t;

  typedef struct packed {
    logic                          valid;
    logic [PHYSICAL_REG_WIDTH-1:0] phys_d_reg;
  } cdb_entry_t;

  // Marks source operands ready when any valid CDB broadcasts their tag.
  function automatic alu_rs_entry_t cdb_wakeup(input alu_rs_entry_t e,
                                               input cdb_entry_t c_alu,
                                               input cdb_entry_t c_mult,
                                               input cdb_entry_t c_br,
                                               input cdb_entry_t c_mem);
    alu_rs_entry_t r;
    cdb_entry_t [NUM_CDB-1:0] bus;
    r   = e;
    bus = {c_mem, c_br, c_mult, c_alu};
    for (int k = 0; k < NUM_CDB; k++) begin
      if (bus[k].valid && (bus[k].phys_d_reg == e.phys_r1)) begin
        r.phys_r1_valid = 1'b1;
      end else begin
        r.phys_r1_valid = r.phys_r1_valid;
      end
      if (bus[k].valid && (bus[k].phys_d_reg == e.phys_r2)) begin
        r.phys_r2_valid = 1'b1;
      end else begin
        r.phys_r2_valid = r.phys_r2_valid;
      end
    end
    return r;
  endfunction

  function automatic alu_rs_entry_t ctrl_resolve(input alu_rs_entry_t e,
                                                 input logic [CONTROL_Q_PTR_WIDTH-1:0] cq,
                                                 input logic resolved);
    alu_rs_entry_t r;
    r = e;
    if (resolved) begin
      r.control_bit_map[cq] = 1'b0;
    end else begin
      r.control_bit_map = e.control_bit_map;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_dispatch.sv
// ALU reservation-station dispatch buffer: small in-order FIFO with CDB snooping,
// branch flush/resolve and wakeup forwarding. Bypass under ALU_RS_DISPATCH_BYPASS_EN.
module alu_rs_dispatch
  import alu_rs_dispatch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  alu_rs_entry_t                  in_entry,
  output logic                           in_ready,
  input  logic                           rs_alu_full,
  output logic                           alu_write,
  output alu_rs_entry_t                  alu_rs_entry,
  input  cdb_entry_t                     cdb_entry_alu,
  input  cdb_entry_t                     cdb_entry_mult,
  input  cdb_entry_t                     cdb_entry_br,
  input  cdb_entry_t                     cdb_entry_mem,
  input  logic                           flush_by_branch,
  input  logic                           branch_resolved,
  input  logic [CONTROL_Q_PTR_WIDTH:0]   control_read_ptr,
  output logic [PTR_W:0]                 count
);

  logic [CONTROL_Q_PTR_WIDTH-1:0] cq_s;
  logic                           unused_cq_msb_s;

  alu_rs_entry_t  slots_q [DEPTH];
  alu_rs_entry_t  slots_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W:0]   count_q, count_d;

  alu_rs_entry_t  in_fwd_s, head_fwd_s, ent_s;
  logic           in_kill_s, bypass_s, deq_s, enq_s, ready_s;
  logic [PTR_W:0]   kept_s;
  logic [PTR_W-1:0] src_s;

  assign cq_s            = control_read_ptr[CONTROL_Q_PTR_WIDTH-1:0];
  assign unused_cq_msb_s = control_read_ptr[CONTROL_Q_PTR_WIDTH];

  function automatic alu_rs_entry_t fixup(input alu_rs_entry_t e);
    return ctrl_resolve(cdb_wakeup(e, cdb_entry_alu, cdb_entry_mult, cdb_entry_br, cdb_entry_mem),
                        cq_s, branch_resolved);
  endfunction

  // Handshake, RS write decision and forwarded output entry.
  always_comb begin
    ready_s    = (count_q < (PTR_W+1)'(DEPTH));
    in_fwd_s   = fixup(in_entry);
    head_fwd_s = fixup(slots_q[head_q]);
    in_kill_s  = flush_by_branch && in_entry.control_bit_map[cq_s];
    bypass_s   = 1'b0;
`ifdef ALU_RS_DISPATCH_BYPASS_EN
    bypass_s   = rst && (count_q == '0) && in_valid && !rs_alu_full && !flush_by_branch;
`endif
    deq_s      = rst && (count_q != '0) && !rs_alu_full && !flush_by_branch;
    enq_s      = in_valid && ready_s && !in_kill_s && !bypass_s;
    in_ready   = rst ? ready_s : 1'b1;
    alu_write  = deq_s || bypass_s;
    if (bypass_s) begin
      alu_rs_entry = in_fwd_s;
    end else begin
      alu_rs_entry = head_fwd_s;
    end
  end

  // Rebuild the buffer in order from the new head: drop the written head and
  // flushed slots, compact survivors, then append the accepted entry.
  always_comb begin
    slots_d = slots_q;
    kept_s  = '0;
    src_s   = head_q;
    ent_s   = slots_q[head_q];
    if (deq_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      src_s = head_q + PTR_W'(i);
      ent_s = fixup(slots_q[src_s]);
      if (((PTR_W+1)'(i) < count_q) &&
          !(flush_by_branch && slots_q[src_s].control_bit_map[cq_s]) &&
          !((i == 0) && deq_s)) begin
        slots_d[head_d + kept_s[PTR_W-1:0]] = ent_s;
        kept_s = kept_s + (PTR_W+1)'(1);
      end else begin
        kept_s = kept_s;
      end
    end
    if (enq_s) begin
      slots_d[head_d + kept_s[PTR_W-1:0]] = in_fwd_s;
      count_d = kept_s + (PTR_W+1)'(1);
    end else begin
      count_d = kept_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= slots_d[i];
      end
    end
  end

  assign count = count_q;

endmodule
